lis3dh_spi_responder: RTL and testbench
=======================================

// Module: lis3dh_spi_responder
// PURPOSE
//  SPI responder emulating the LIS3DH accelerometer's register interface. It is the far end of the
//  Nios SPI master link (SCLK/MOSI/MISO/SS_n) plus the two interrupt lines read by the LIS3DH PIO.
//  Serves a 64-byte register map; XYZ samples arrive on a parallel stimulus port. Used in system
//  simulation and on board when no sensor is fitted.
// PARAMETERS
//  SYNC_STAGES   2      flops in each SCLK/MOSI/SS_n synchroniser (>=2)
//  WHO_AM_I_VAL  8'h33  value returned at address 0x0F
// PORTS
//  clk_clk        in   1   system clock; all logic in this domain
//  reset_reset    in   1   asynchronous, active-high reset
//  spi_sclk       in   1   SPI clock, mode 3 (CPOL=1, CPHA=1), idles high
//  spi_mosi       in   1   command/write data, MSB first
//  spi_ss_n       in   1   chip select, active low
//  spi_miso       out  1   read data, MSB first
//  spi_miso_oe    out  1   MISO output enable (1 only in RD state)
//  sample_x/y/z   in   16  signed two's-complement sample per axis
//  sample_valid   in   1   one-clk strobe: capture sample_x/y/z
//  int1           out  1   data-ready interrupt
//  int2           out  1   overrun interrupt
// BEHAVIOUR
//  Reset: all outputs 0. Regs 0x00 except 0x0F=WHO_AM_I_VAL and CTRL_REG1 (0x20)=8'h07. State IDLE.
//  Inputs pass through SYNC_STAGES flops plus an edge detector. Requirement: SCLK high/low time
//  >= SYNC_STAGES+3 clk. MISO update latency after SCLK fall is <= SYNC_STAGES+2 clk.
//  FSM IDLE -> CMD on synced SS_n fall; bit counter cleared.
//  Each synced SCLK rise while SS_n low shifts MOSI into an 8-bit register; 3-bit counter wraps 7->0.
//  CMD, 8th bit: latch rw=b7, ms=b6, addr=b5:0. rw=1 -> RD, rw=0 -> WR.
//  RD: load shift_out=reg[addr] at command completion. Drive bit7 with oe=1 on the next SCLK fall.
//   Shift one bit on every later SCLK fall.
//  RD byte boundary: if ms, addr+=1 (6-bit, 0x3F wraps to 0x00); else addr holds. Load the next byte.
//  WR, each full byte: write reg[addr] if addr is in 0x1F..0x25, otherwise ignore. Then advance addr as in RD.
//  Unimplemented addresses read 8'h00. Reads of 0x0F and 0x27..0x2D never alter values, except the
//   status clear below.
//  SS_n rise in any state: go to IDLE, oe=0, discard any partial byte (no write).
//  SS_n fall while not IDLE is impossible; SS_n rise always returns to IDLE first.
//  Register map: STATUS 0x27; OUT_X_L/H 0x28/29, OUT_Y_L/H 0x2A/2B, OUT_Z_L/H 0x2C/2D (little endian).
//  Sample capture, SS_n high: OUT regs <= samples. Then, if STATUS[3] was already 1, STATUS[7:4]<=4'hF
//   (overrun); always STATUS[3:0]<=4'hF.
//  sample_valid while SS_n low: store in a one-deep pending buffer; apply on the clk after SS_n rise.
//   A second strobe replaces the pending sample and forces overrun on apply.
//  Reading OUT_Z_H (0x2D) clears STATUS to 8'h00 once that byte is fully shifted out (8th SCLK rise).
//   A pending apply in the same clk has priority.
//  int1 = registered STATUS[3] & CTRL_REG3[4]. int2 = registered STATUS[7] & CTRL_REG6[6].
//   Each lags STATUS by 1 clk.
//  Reset mid-transaction: immediate return to reset state; pending sample lost.
// STRUCTURE
//  Package lis3dh_pkg holds:
//   - address localparams (WHO_AM_I, CTRL_REG1..6, STATUS, OUT_*)
//   - reset values and the writable-range bounds
//   - state enum {IDLE, CMD, RD, WR}
//  Sub-module spi_sync_edge: SYNC_STAGES synchroniser with rise/fall strobes. One instance each for
//   SCLK, SS_n and MOSI (edges unused for MOSI).
//  Register file, FSM, shifters and sample logic stay in this module.
// TESTING
//  Read 0x8F then one dummy byte -> MISO returns 8'h33; oe=1 only between command end and SS_n rise.
//  Write 0x60,0x97,0x00,0x10 (ms, start 0x20) -> CTRL_REG1=0x97, CTRL_REG2=0x00, CTRL_REG3=0x10;
//   burst read 0xE0 returns 97,00,10.
//  sample_valid with x=16'h1234, y=16'hFFFE, z=16'h8000 -> STATUS=0x0F and int1=1.
//   Burst read 0xE8 returns 34,12,FE,FF,00,80; after the 8th SCLK rise of byte 0x2D, STATUS=0 and int1=0.
//  Two sample_valid strobes with no read between -> STATUS=0xFF, int2=1 when CTRL_REG6[6]=1.
//   A strobe during SS_n low is deferred: STATUS unchanged until SS_n rise.
//  Write 0x3F (no ms) with 2 bytes -> no register changes.
//   Read 0xFF: byte0=reg 0x3F=0x00, byte1=reg 0x00 (wrap).
//  SS_n rise after 5 data bits of a write to 0x20 -> CTRL_REG1 unchanged.
//   Reset asserted mid-read -> oe=0, regs at defaults.

Source files
------------

// File: rtl/lis3dh_pkg.sv
// Shared constants and types for the LIS3DH SPI register-interface emulator.
package lis3dh_pkg;

  localparam logic [5:0] WHO_AM_I   = 6'h0F;
  localparam logic [5:0] TEMP_CFG   = 6'h1F;
  localparam logic [5:0] CTRL_REG1  = 6'h20;
  localparam logic [5:0] CTRL_REG2  = 6'h21;
  localparam logic [5:0] CTRL_REG3  = 6'h22;
  localparam logic [5:0] CTRL_REG4  = 6'h23;
  localparam logic [5:0] CTRL_REG5  = 6'h24;
  localparam logic [5:0] CTRL_REG6  = 6'h25;
  localparam logic [5:0] STATUS_REG = 6'h27;
  localparam logic [5:0] OUT_X_L    = 6'h28;
  localparam logic [5:0] OUT_X_H    = 6'h29;
  localparam logic [5:0] OUT_Y_L    = 6'h2A;
  localparam logic [5:0] OUT_Y_H    = 6'h2B;
  localparam logic [5:0] OUT_Z_L    = 6'h2C;
  localparam logic [5:0] OUT_Z_H    = 6'h2D;

  localparam logic [5:0] WR_LO  = TEMP_CFG;
  localparam logic [5:0] WR_HI  = CTRL_REG6;
  localparam int         NUM_WR = 7;

  localparam logic [7:0] CTRL_REG1_RST = 8'h07;

  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_e;

  typedef struct packed {
    logic [15:0] z;
    logic [15:0] y;
    logic [15:0] x;
  } sample_t;

endpackage

// File: rtl/lis3dh_spi_responder_spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI pin with one-clk rise/fall strobes.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/lis3dh_spi_responder.sv
// LIS3DH register-interface emulator: SPI mode 3 responder, register file, sample capture, interrupts.
module lis3dh_spi_responder
  import lis3dh_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h33
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        int1,
  output logic        int2
);

  logic       sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic       sclk_lvl_unused, ss_lvl_unused;
  logic [1:0] mosi_edge_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
    .clk_i(clk_clk), .rst_i(reset_reset), .d_i(spi_sclk),
    .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk_i(clk_clk), .rst_i(reset_reset), .d_i(spi_ss_n),
    .q_o(ss_lvl_unused), .rise_o(ss_rise), .fall_o(ss_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk_i(clk_clk), .rst_i(reset_reset), .d_i(spi_mosi),
    .q_o(mosi_s), .rise_o(mosi_edge_unused[0]), .fall_o(mosi_edge_unused[1]));

  state_e                  state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [6:0]              rx_q, rx_d;
  logic                    ms_q, ms_d;
  logic [5:0]              addr_q, addr_d;
  logic [7:0]              shift_q, shift_d;
  logic                    hold_q, hold_d;
  logic                    oe_q, oe_d;
  logic [NUM_WR-1:0][7:0]  wr_q, wr_d;
  logic [7:0]              status_q, status_d;
  logic [5:0][7:0]         out_q, out_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    pend_ovr_q, pend_ovr_d;
  sample_t                 pend_q, pend_d;
  logic                    int1_q, int2_q;

  logic [7:0] byte_in, rd_data;
  logic [5:0] rd_addr;
  logic       byte_done, clr_status, ovr;
  sample_t    smp;

  assign byte_in   = {rx_q, mosi_s};
  assign byte_done = sclk_rise && (state_q != IDLE) && (bit_cnt_q == 3'd7);
  // Address of the byte to preload: the command's address, or the next burst address.
  assign rd_addr   = (state_q == CMD) ? byte_in[5:0] : (ms_q ? addr_q + 6'd1 : addr_q);

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr == WHO_AM_I)                             rd_data = WHO_AM_I_VAL;
    else if (rd_addr >= WR_LO && rd_addr <= WR_HI)       rd_data = wr_q[3'(rd_addr - WR_LO)];
    else if (rd_addr == STATUS_REG)                      rd_data = status_q;
    else if (rd_addr >= OUT_X_L && rd_addr <= OUT_Z_H)   rd_data = out_q[3'(rd_addr - OUT_X_L)];
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    ms_d       = ms_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    oe_d       = oe_q;
    wr_d       = wr_q;
    status_d   = status_q;
    out_d      = out_q;
    pend_vld_d = pend_vld_q;
    pend_ovr_d = pend_ovr_q;
    pend_d     = pend_q;
    clr_status = 1'b0;
    ovr        = 1'b0;
    smp        = pend_q;

    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
      end
    end else begin
      if (sclk_rise) begin
        rx_d      = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        if (state_q == CMD) begin
          ms_d    = byte_in[6];
          addr_d  = byte_in[5:0];
          state_d = byte_in[7] ? RD : WR;
          if (byte_in[7]) begin
            shift_d = rd_data;
            hold_d  = 1'b1;
          end
        end else begin
          addr_d = rd_addr;
          if (state_q == RD) begin
            shift_d    = rd_data;
            hold_d     = 1'b1;
            clr_status = (addr_q == OUT_Z_H);
          end else if (addr_q >= WR_LO && addr_q <= WR_HI) begin
            wr_d[3'(addr_q - WR_LO)] = byte_in;
          end
        end
      end
      // The first fall after a byte load only enables the driver; bit 7 is already in place.
      if (sclk_fall && state_q == RD) begin
        if (hold_q) begin
          hold_d = 1'b0;
          oe_d   = 1'b1;
        end else begin
          shift_d = {shift_q[6:0], 1'b0};
        end
      end
      if (ss_rise) begin
        state_d   = IDLE;
        oe_d      = 1'b0;
        hold_d    = 1'b0;
        bit_cnt_d = 3'd0;
      end
    end

    if (clr_status) status_d = 8'h00;

    if (state_q == IDLE) begin
      if (sample_valid || pend_vld_q) begin
        smp        = sample_valid ? sample_t'({sample_z, sample_y, sample_x}) : pend_q;
        ovr        = status_q[3] | (pend_vld_q & (pend_ovr_q | sample_valid));
        out_d      = {smp.z, smp.y, smp.x};
        status_d   = {ovr ? 4'hF : status_q[7:4], 4'hF};
        pend_vld_d = 1'b0;
        pend_ovr_d = 1'b0;
      end
    end else if (sample_valid) begin
      pend_vld_d = 1'b1;
      pend_ovr_d = pend_ovr_q | pend_vld_q;
      pend_d     = sample_t'({sample_z, sample_y, sample_x});
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      ms_q       <= 1'b0;
      addr_q     <= '0;
      shift_q    <= '0;
      hold_q     <= 1'b0;
      oe_q       <= 1'b0;
      wr_q       <= '0;
      wr_q[3'(CTRL_REG1 - WR_LO)] <= CTRL_REG1_RST;
      status_q   <= '0;
      out_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_ovr_q <= 1'b0;
      pend_q     <= '0;
      int1_q     <= 1'b0;
      int2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      ms_q       <= ms_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      oe_q       <= oe_d;
      wr_q       <= wr_d;
      status_q   <= status_d;
      out_q      <= out_d;
      pend_vld_q <= pend_vld_d;
      pend_ovr_q <= pend_ovr_d;
      pend_q     <= pend_d;
      int1_q     <= status_q[3] & wr_q[3'(CTRL_REG3 - WR_LO)][4];
      int2_q     <= status_q[7] & wr_q[3'(CTRL_REG6 - WR_LO)][6];
    end
  end

  assign spi_miso    = oe_q & shift_q[7];
  assign spi_miso_oe = oe_q;
  assign int1        = int1_q;
  assign int2        = int2_q;

endmodule

// File: tb/tb_lis3dh_spi_responder.sv
// Scoreboard bench: expected MISO bytes queued by the stimulus, compared by a monitor as they arrive.
`timescale 1ns/1ps
module tb_lis3dh_spi_responder;

  logic        clk = 1'b0, rst = 1'b1;
  logic        sclk = 1'b1, mosi = 1'b0, ss_n = 1'b1;
  logic        miso, miso_oe, int1, int2;
  logic [15:0] sx = '0, sy = '0, sz = '0;
  logic        svalid = 1'b0;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  lis3dh_spi_responder #(.SYNC_STAGES(2), .WHO_AM_I_VAL(8'h33)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .spi_sclk(sclk), .spi_mosi(mosi), .spi_ss_n(ss_n),
    .spi_miso(miso), .spi_miso_oe(miso_oe),
    .sample_x(sx), .sample_y(sy), .sample_z(sz), .sample_valid(svalid),
    .int1(int1), .int2(int2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [7:0] sh = '0;
    int nb = 0;
    forever begin
      @(posedge sclk or posedge ss_n);
      if (ss_n) nb = 0;
      else if (miso_oe) begin
        sh = {sh[6:0], miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_byte: got %0h expected nothing", sh);
          end else chk("rd_byte", {24'h0, sh}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  endtask

  task automatic clks(input int n); repeat (n) @(posedge clk); endtask

  task automatic spi_start(); ss_n = 1'b0; clks(8); endtask
  task automatic spi_end();   ss_n = 1'b1; clks(10); endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0; mosi = b[i]; clks(8);
      sclk = 1'b1; clks(8);
    end
  endtask

  task automatic spi_byte(input logic [7:0] b); spi_bits(b, 8); endtask

  task automatic spi_write(input logic [7:0] cmd, input logic [7:0] d [$]);
    spi_start(); spi_byte(cmd);
    foreach (d[i]) spi_byte(d[i]);
    spi_end();
  endtask

  task automatic spi_read(input logic [7:0] cmd, input logic [7:0] e [$]);
    foreach (e[i]) exp_q.push_back(e[i]);
    spi_start(); spi_byte(cmd);
    foreach (e[i]) spi_byte(8'h00);
    spi_end();
  endtask

  task automatic sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk); sx = x; sy = y; sz = z; svalid = 1'b1;
    @(negedge clk); svalid = 1'b0;
    clks(3); @(negedge clk);
  endtask

  task automatic stimulus();
    clks(4); @(negedge clk);
    chk("rst_oe", {31'h0, miso_oe}, 0);
    chk("rst_miso", {31'h0, miso}, 0);
    chk("rst_int1", {31'h0, int1}, 0);
    chk("rst_int2", {31'h0, int2}, 0);
    rst = 1'b0; clks(4);

    // WHO_AM_I with driver-enable window
    exp_q.push_back(8'h33);
    spi_start(); spi_byte(8'h8F);
    @(negedge clk); chk("oe_cmd", {31'h0, miso_oe}, 0);
    spi_byte(8'h00);
    @(negedge clk); chk("oe_data", {31'h0, miso_oe}, 1);
    spi_end();
    @(negedge clk); chk("oe_idle", {31'h0, miso_oe}, 0);

    spi_write(8'h60, '{8'h97, 8'h00, 8'h10});
    spi_read(8'hE0, '{8'h97, 8'h00, 8'h10});

    sample(16'h1234, 16'hFFFE, 16'h8000);
    chk("int1_set", {31'h0, int1}, 1);
    spi_read(8'hA7, '{8'h0F});
    foreach (exp_q[i]) ;
    exp_q.push_back(8'h34); exp_q.push_back(8'h12); exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h80);
    spi_start(); spi_byte(8'hE8);
    for (int i = 0; i < 6; i++) spi_byte(8'h00);
    @(negedge clk); chk("int1_clr", {31'h0, int1}, 0);
    spi_end();
    spi_read(8'hA7, '{8'h00});

    // overrun
    spi_write(8'h25, '{8'h40});
    sample(16'h0001, 16'h0002, 16'h0303);
    chk("int2_lo", {31'h0, int2}, 0);
    sample(16'h0001, 16'h0002, 16'h0303);
    chk("int2_set", {31'h0, int2}, 1);
    spi_read(8'hA7, '{8'hFF});
    spi_read(8'hAD, '{8'h03});
    @(negedge clk); chk("int2_clr", {31'h0, int2}, 0);

    // strobe during SS_n low is deferred
    exp_q.push_back(8'h00);
    spi_start();
    sample(16'h5AA5, 16'h0000, 16'h0000);
    chk("defer_int1", {31'h0, int1}, 0);
    spi_byte(8'hA7); spi_byte(8'h00);
    spi_end();
    @(negedge clk); chk("apply_int1", {31'h0, int1}, 1);
    spi_read(8'hA7, '{8'h0F});
    spi_read(8'hA8, '{8'hA5});

    // out-of-range write, wrap read
    spi_write(8'h3F, '{8'hAA, 8'h55});
    spi_read(8'hE0, '{8'h97, 8'h00, 8'h10});
    spi_read(8'hFF, '{8'h00, 8'h00});

    // non-burst write lands on one address; burst write stops at range edge
    spi_write(8'h21, '{8'h11, 8'h22});
    spi_read(8'hA1, '{8'h22});
    spi_write(8'h64, '{8'hAB, 8'hCD, 8'hEF});
    spi_read(8'hE4, '{8'hAB, 8'hCD, 8'h00});

    // partial byte discarded
    spi_start(); spi_byte(8'h20); spi_bits(8'h55, 5); sclk = 1'b1; spi_end();
    spi_read(8'hA0, '{8'h97});

    // reset mid-read
    spi_start(); spi_byte(8'hA0); spi_bits(8'h00, 3);
    @(negedge clk); chk("rd_oe_pre", {31'h0, miso_oe}, 1);
    rst = 1'b1; @(negedge clk);
    chk("rst_mid_oe", {31'h0, miso_oe}, 0);
    clks(2); rst = 1'b0; sclk = 1'b1; spi_end();
    spi_read(8'hA0, '{8'h07});
    spi_read(8'hA2, '{8'h00});
    spi_read(8'hA7, '{8'h00});
    @(negedge clk); chk("rst_int1_after", {31'h0, int1}, 0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #2_000_000;
        checks++; errors++;
        $display("FAIL watchdog: got timeout expected completion");
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
